// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM tile sequencer.
//   gemm_state_t : sequencer FSM state encoding
//   LOAD_SEL_A/B : values of iload_sel choosing the operand bank
//   clog2_min1   : index width that never collapses to zero bits
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT,
        DONE
    } gemm_state_t;

    localparam logic LOAD_SEL_A = 1'b0;
    localparam logic LOAD_SEL_B = 1'b1;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/gemm_idx_counter.sv
// Nested i/j/k index counter for the GEMM tile sequencer.
//   iclk, irst  : clock, synchronous active-high reset
//   i_clr       : return all indices to zero
//   i_inc_k     : advance k (wraps to 0 after K-1)
//   i_inc_ij    : advance j, wrapping to 0 with i++ (i wraps after M-1)
//   o_i/o_j/o_k : current indices
//   o_last_k    : k == K-1
//   o_last_ij   : (i, j) == (M-1, N-1)
module gemm_idx_counter
    import gemm_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4,
    parameter int K = 4,
    localparam int IW = clog2_min1(M),
    localparam int JW = clog2_min1(N),
    localparam int KW = clog2_min1(K)
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          i_clr,
    input  logic          i_inc_k,
    input  logic          i_inc_ij,
    output logic [IW-1:0] o_i,
    output logic [JW-1:0] o_j,
    output logic [KW-1:0] o_k,
    output logic          o_last_k,
    output logic          o_last_ij
);

    logic [IW-1:0] r_i;
    logic [JW-1:0] r_j;
    logic [KW-1:0] r_k;
    logic          w_last_i;
    logic          w_last_j;

    assign w_last_i  = (r_i == IW'(M - 1));
    assign w_last_j  = (r_j == JW'(N - 1));
    assign o_last_k  = (r_k == KW'(K - 1));
    assign o_last_ij = w_last_i && w_last_j;

    always_ff @(posedge iclk) begin
        if (irst || i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            if (i_inc_k) begin
                r_k <= o_last_k ? '0 : r_k + KW'(1);
            end
            if (i_inc_ij) begin
                if (w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + IW'(1);
                end else begin
                    r_j <= r_j + JW'(1);
                end
            end
        end
    end

    assign o_i = r_i;
    assign o_j = r_j;
    assign o_k = r_k;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Initiator side of the MAC tile interface. Holds the A (MxK) and B (KxN)
// operands, walks C[i][j] row-major issuing one operand pair per cycle to an
// external 1-cycle-latency MAC, feeds the running sum back, and streams each
// finished C element out on a valid/ready handshake.
//   iclk, irst                          : clock, synchronous active-high reset
//   iload_valid/oload_ready/iload_sel/
//   iload_addr/iload_data               : operand write port (IDLE only)
//   istart, obusy, odone                : run control/status
//   oa_tile, ob_tile, ocurr_sum, isum   : MAC interface
//   oc_valid, ic_ready, oc_data,
//   oc_row, oc_col                      : result stream
//
// state | meaning
// IDLE  | accepting loads, waiting for istart
// MAC   | issuing k = 0..K-1 for the current C[i][j]
// DRAIN | last product emerging from the MAC; capture into oc_data
// OUT   | presenting C[i][j] until accepted
// DONE  | one-cycle odone pulse
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4,
    localparam int A_SIZE = MATRIX_HEIGHT * MATRIX_ADJUST,
    localparam int B_SIZE = MATRIX_ADJUST * MATRIX_WIDTH,
    localparam int ADDR_W = clog2_min1((A_SIZE > B_SIZE) ? A_SIZE : B_SIZE),
    localparam int ROW_W  = clog2_min1(MATRIX_HEIGHT),
    localparam int COL_W  = clog2_min1(MATRIX_WIDTH),
    localparam int K_W    = clog2_min1(MATRIX_ADJUST)
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  iload_valid,
    output logic                  oload_ready,
    input  logic                  iload_sel,
    input  logic [ADDR_W-1:0]     iload_addr,
    input  logic [DATA_WIDTH-1:0] iload_data,
    input  logic                  istart,
    output logic                  obusy,
    output logic                  odone,
    output logic [DATA_WIDTH-1:0] oa_tile,
    output logic [DATA_WIDTH-1:0] ob_tile,
    output logic [DATA_WIDTH-1:0] ocurr_sum,
    input  logic [DATA_WIDTH-1:0] isum,
    output logic                  oc_valid,
    input  logic                  ic_ready,
    output logic [DATA_WIDTH-1:0] oc_data,
    output logic [ROW_W-1:0]      oc_row,
    output logic [COL_W-1:0]      oc_col
);

    localparam int A_AW = clog2_min1(A_SIZE);
    localparam int B_AW = clog2_min1(B_SIZE);

    gemm_state_t r_state;
    gemm_state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem_a [A_SIZE];
    logic [DATA_WIDTH-1:0] r_mem_b [B_SIZE];
    logic [DATA_WIDTH-1:0] r_c_data;

    logic [ROW_W-1:0] w_i;
    logic [COL_W-1:0] w_j;
    logic [K_W-1:0]   w_k;
    logic             w_last_k;
    logic             w_last_ij;
    logic             w_clr;
    logic             w_inc_k;
    logic             w_inc_ij;
    logic             w_capture;
    logic             w_load_a;
    logic             w_load_b;
    logic [A_AW-1:0]  w_a_idx;
    logic [B_AW-1:0]  w_b_idx;

    gemm_idx_counter #(
        .M (MATRIX_HEIGHT),
        .N (MATRIX_WIDTH),
        .K (MATRIX_ADJUST)
    ) u_idx (
        .iclk      (iclk),
        .irst      (irst),
        .i_clr     (w_clr),
        .i_inc_k   (w_inc_k),
        .i_inc_ij  (w_inc_ij),
        .o_i       (w_i),
        .o_j       (w_j),
        .o_k       (w_k),
        .o_last_k  (w_last_k),
        .o_last_ij (w_last_ij)
    );

    // Out-of-range addresses are silently dropped.
    assign w_load_a = iload_valid && oload_ready && (iload_sel == LOAD_SEL_A)
                      && (int'(iload_addr) < A_SIZE);
    assign w_load_b = iload_valid && oload_ready && (iload_sel == LOAD_SEL_B)
                      && (int'(iload_addr) < B_SIZE);

    always_ff @(posedge iclk) begin
        if (w_load_a) begin
            r_mem_a[A_AW'(iload_addr)] <= iload_data;
        end
        if (w_load_b) begin
            r_mem_b[B_AW'(iload_addr)] <= iload_data;
        end
    end

    assign w_a_idx = A_AW'(int'(w_i) * MATRIX_ADJUST + int'(w_k));
    assign w_b_idx = B_AW'(int'(w_k) * MATRIX_WIDTH + int'(w_j));

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc_k     = 1'b0;
        w_inc_ij    = 1'b0;
        w_capture   = 1'b0;
        oa_tile     = '0;
        ob_tile     = '0;
        ocurr_sum   = '0;
        oc_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (istart) begin
                    w_state_nxt = MAC;
                    w_clr       = 1'b1;
                end
            end
            MAC: begin
                oa_tile   = r_mem_a[w_a_idx];
                ob_tile   = r_mem_b[w_b_idx];
                // isum holds the previous issue's result; k==0 starts a fresh sum.
                ocurr_sum = (w_k == '0) ? '0 : isum;
                w_inc_k   = 1'b1;
                if (w_last_k) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_capture   = 1'b1;
                w_state_nxt = OUT;
            end
            OUT: begin
                oc_valid = 1'b1;
                if (ic_ready) begin
                    w_inc_ij    = 1'b1;
                    w_state_nxt = w_last_ij ? DONE : MAC;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_c_data <= '0;
        end else if (w_capture) begin
            r_c_data <= isum;
        end
    end

    assign oload_ready = (r_state == IDLE);
    assign obusy       = (r_state == MAC) || (r_state == DRAIN) || (r_state == OUT);
    assign odone       = (r_state == DONE);
    assign oc_data     = r_c_data;
    assign oc_row      = w_i;
    assign oc_col      = w_j;

endmodule
